me_full_search: RTL and testbench
=================================

# me_full_search

Parameterised full-search motion-estimation engine for the inter-prediction path. It scans every integer candidate position of a MACRO_DIM×MACRO_DIM current macroblock inside a SEARCH_DIM×SEARCH_DIM search window and reports the minimum SAD together with its signed motion vector. Pixels are fetched row by row through a one-cycle-latency read interface to the external window/macroblock buffers. It extends the fixed-size SAD-only engine with vector output, a handshake, and an optional early-termination mode.

## Interface
- MACRO_DIM, 16, macroblock edge in pixels (≥2)
- SEARCH_DIM, 48, search-window edge in pixels (> MACRO_DIM)
- SAD_W, 16, SAD width; must satisfy 2^SAD_W > MACRO_DIM²·255
- Derived: P = SEARCH_DIM−MACRO_DIM+1 positions per axis; C = (P−1)/2 centre offset; MV_W = $clog2(P)+1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin search; honoured only while busy=0
- busy  out  1  high from the cycle after start is accepted until the valid cycle inclusive
- rd_en  out  1  row read request
- rd_x  out  $clog2(P)  candidate column offset in window
- rd_y  out  $clog2(P)  candidate row offset in window
- rd_row  out  $clog2(MACRO_DIM)  row within macroblock
- pixel_cpr_in  in  8×MACRO_DIM  current-MB row rd_row, valid the cycle after rd_en
- pixel_spr_in  in  8×MACRO_DIM  window row rd_y+rd_row, columns rd_x..rd_x+MACRO_DIM−1, valid the cycle after rd_en
- valid  out  1  one-cycle result strobe
- min_sad  out  SAD_W  best SAD, held until next start
- mv_x, mv_y  out  MV_W signed  best offset: rd_x−C, rd_y−C

## Operation
- FSM: IDLE → SEARCH → DRAIN → DONE → IDLE.
- IDLE: start=1 latches nothing else; next cycle SEARCH. Internal best_sad set to all-ones, first-candidate flag set.
- SEARCH: one read per cycle, raster order: rd_row fastest (0..MACRO_DIM−1), then rd_x (0..P−1), then rd_y (0..P−1).
- Each data cycle: row_sad = Σ|cpr[i]−spr[i]| over MACRO_DIM pixels, added to accumulator acc (SAD_W bits, cannot overflow given SAD_W rule).
- On the last row of a candidate: if acc+row_sad < best_sad (strict), update best_sad and best position; acc cleared. Ties keep the earlier candidate in raster order.
- After the final read issues, DRAIN waits one cycle for its data; DONE drives valid=1 for one cycle, registers min_sad/mv_x/mv_y, returns to IDLE.
- start while busy: ignored, no effect on the search in progress.
- rst at any cycle: FSM to IDLE next edge; in-flight data discarded.

## Timing
- Reset values: busy=0, rd_en=0, rd_x=rd_y=rd_row=0, valid=0, min_sad=0, mv_x=mv_y=0.
- start sampled high at edge 0 → rd_en high cycles 1..K, K=P²·MACRO_DIM, continuously (no bubbles, early-term off).
- Data for the read at cycle t consumed at cycle t+1; accumulator/best registers update at the end of t+1.
- valid high in cycle K+2; outputs stable from cycle K+2 until the next accepted start. Defaults: K=17424, valid at 17426.
- Next start accepted from cycle K+3 (IDLE).

## Configuration
- ME_EARLY_TERM_EN defined: in a data cycle where acc+row_sad ≥ best_sad (not first candidate), the candidate is abandoned; read address jumps to row 0 of the next candidate on the following cycle; the one read already in flight returns data that is ignored (tagged invalid). Abandoned candidates never update best. Results identical to undefined case; total cycles ≤ K+2.
- Undefined: no abandonment, fixed latency K+2.

## Test plan
- Reset: hold rst 3 cycles with start=1 → all outputs at reset values, no rd_en.
- Flat frames (all pixels 0x80) → min_sad=0, mv=(−16,−16) (first candidate, tie rule), valid at cycle 17426.
- Current MB copied into window at offset rd_x=19, rd_y=11, other pixels random → min_sad=0, mv_x=+3, mv_y=−5.
- Window = current MB + 1 everywhere except exact match at centre → min_sad=0, mv=(0,0); with ME_EARLY_TERM_EN, valid earlier than cycle 17426 and identical outputs.
- start pulsed again at cycle 100 of a search → ignored, single valid strobe at 17426.
- rst asserted at cycle 5000 then new start → fresh search, result matches stimulus of second run only.

Source files
------------

// File: rtl/me_full_search.sv
// me_full_search: full-search SAD motion estimator; define ME_EARLY_TERM_EN to abandon losing candidates early.
module me_full_search #(
  parameter int MACRO_DIM = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W = 16,
  localparam int P = SEARCH_DIM - MACRO_DIM + 1,
  localparam int C = (P - 1) / 2,
  localparam int XW = $clog2(P),
  localparam int RW = $clog2(MACRO_DIM),
  localparam int MV_W = XW + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      rd_en,
  output logic [XW-1:0]             rd_x,
  output logic [XW-1:0]             rd_y,
  output logic [RW-1:0]             rd_row,
  input  logic [8*MACRO_DIM-1:0]    pixel_cpr_in,
  input  logic [8*MACRO_DIM-1:0]    pixel_spr_in,
  output logic                      valid,
  output logic [SAD_W-1:0]          min_sad,
  output logic signed [MV_W-1:0]    mv_x,
  output logic signed [MV_W-1:0]    mv_y
);
  localparam logic signed [MV_W-1:0] CV = MV_W'(C);
  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;
  state_t state;
  logic [SAD_W-1:0] acc, best_sad, row_sad;
  logic [SAD_W:0] sum;
  logic [XW-1:0] best_x, best_y, d_x, d_y, fin_x, fin_y;
  logic first, d_vld, d_last, upd, abandon, last_row, last_x, last_y;
  always_comb begin
    row_sad = '0;
    for (int i = 0; i < MACRO_DIM; i++)
      row_sad = row_sad + SAD_W'(pixel_cpr_in[8*i+:8] > pixel_spr_in[8*i+:8] ?
                pixel_cpr_in[8*i+:8] - pixel_spr_in[8*i+:8] :
                pixel_spr_in[8*i+:8] - pixel_cpr_in[8*i+:8]);
  end
  assign sum = {1'b0, acc} + {1'b0, row_sad};
  assign upd = d_vld && d_last && (first || sum < {1'b0, best_sad});
`ifdef ME_EARLY_TERM_EN
  assign abandon = d_vld && !d_last && !first && sum >= {1'b0, best_sad};
`else
  assign abandon = 1'b0;
`endif
  assign last_row = rd_row == RW'(MACRO_DIM - 1);
  assign last_x = rd_x == XW'(P - 1);
  assign last_y = rd_y == XW'(P - 1);
  assign fin_x = upd ? d_x : best_x;
  assign fin_y = upd ? d_y : best_y;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      rd_en <= 1'b0;
      rd_x <= '0;
      rd_y <= '0;
      rd_row <= '0;
      valid <= 1'b0;
      min_sad <= '0;
      mv_x <= '0;
      mv_y <= '0;
      acc <= '0;
      best_sad <= '1;
      best_x <= '0;
      best_y <= '0;
      first <= 1'b1;
      d_vld <= 1'b0;
      d_last <= 1'b0;
      d_x <= '0;
      d_y <= '0;
    end else begin
      // the read issued alongside an abandon belongs to the dropped candidate
      d_vld <= rd_en && !abandon;
      d_last <= last_row;
      d_x <= rd_x;
      d_y <= rd_y;
      if (d_vld) acc <= (d_last || abandon) ? '0 : sum[SAD_W-1:0];
      if (upd) begin
        best_sad <= sum[SAD_W-1:0];
        best_x <= d_x;
        best_y <= d_y;
        first <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state <= SEARCH;
          busy <= 1'b1;
          rd_en <= 1'b1;
          rd_x <= '0;
          rd_y <= '0;
          rd_row <= '0;
          acc <= '0;
          best_sad <= '1;
          first <= 1'b1;
        end
        SEARCH: begin
          if ((abandon || last_row) && last_x && last_y) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else if (abandon || last_row) begin
            rd_row <= '0;
            rd_x <= last_x ? '0 : rd_x + 1'b1;
            rd_y <= last_x ? rd_y + 1'b1 : rd_y;
          end else begin
            rd_row <= rd_row + 1'b1;
          end
        end
        DRAIN: begin
          state <= DONE;
          valid <= 1'b1;
          min_sad <= upd ? sum[SAD_W-1:0] : best_sad;
          mv_x <= $signed({1'b0, fin_x}) - CV;
          mv_y <= $signed({1'b0, fin_y}) - CV;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_me_full_search.sv
// tb_me_full_search: directed checks of me_full_search with a behavioural pixel buffer.
module tb_me_full_search;
  localparam int M = 16;
  localparam int S = 48;
  localparam int K = 33 * 33 * 16;
  localparam int LIM = K + 40;
  logic clk = 1'b0;
  logic rst, start, busy, rd_en, valid;
  logic [5:0] rd_x, rd_y;
  logic [3:0] rd_row;
  logic [8*M-1:0] pixel_cpr_in, pixel_spr_in;
  logic [15:0] min_sad;
  logic signed [6:0] mv_x, mv_y;
  logic [7:0] cur [M][M];
  logic [7:0] win [S][S];
  int checks = 0;
  int fails = 0;

  me_full_search dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_row(rd_row),
    .pixel_cpr_in(pixel_cpr_in), .pixel_spr_in(pixel_spr_in),
    .valid(valid), .min_sad(min_sad), .mv_x(mv_x), .mv_y(mv_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en)
      for (int i = 0; i < M; i++) begin
        pixel_cpr_in[8*i+:8] <= cur[rd_row][i];
        pixel_spr_in[8*i+:8] <= win[int'(rd_y) + int'(rd_row)][int'(rd_x) + i];
      end

  task automatic run_search(input int pulse_at, output int n, output logic b1,
                            output logic [3:0] r2, output logic [5:0] x17);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    b1 = busy;
    r2 = '0;
    x17 = '0;
    while (!valid && n < LIM) begin
      if (n == 2) r2 = rd_row;
      if (n == 17) x17 = rd_x;
      start = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0d exp 0", busy); end
    if (rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %0d exp 0", rd_en); end
    if (rd_x !== 6'd0) begin fails++; $display("FAIL reset_rd_x got %0d exp 0", rd_x); end
    if (rd_y !== 6'd0) begin fails++; $display("FAIL reset_rd_y got %0d exp 0", rd_y); end
    if (rd_row !== 4'd0) begin fails++; $display("FAIL reset_rd_row got %0d exp 0", rd_row); end
    if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0d exp 0", valid); end
    if (min_sad !== 16'd0) begin fails++; $display("FAIL reset_min_sad got %0d exp 0", min_sad); end
    if (mv_x !== 7'sd0) begin fails++; $display("FAIL reset_mv_x got %0d exp 0", mv_x); end
    if (mv_y !== 7'sd0) begin fails++; $display("FAIL reset_mv_y got %0d exp 0", mv_y); end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_flat_and_ignored_start;
    int n;
    logic b1;
    logic [3:0] r2;
    logic [5:0] x17;
    for (int r = 0; r < M; r++) for (int c = 0; c < M; c++) cur[r][c] = 8'h80;
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) win[r][c] = 8'h80;
    run_search(100, n, b1, r2, x17);
    checks += 9;
`ifdef ME_EARLY_TERM_EN
    if (!valid || n > K + 2) begin fails++; $display("FAIL flat_latency got %0d exp <=%0d", n, K + 2); end
`else
    if (!valid || n != K + 2) begin fails++; $display("FAIL flat_latency got %0d exp %0d", n, K + 2); end
`endif
    if (b1 !== 1'b1) begin fails++; $display("FAIL flat_busy_c1 got %0d exp 1", b1); end
    if (r2 !== 4'd1) begin fails++; $display("FAIL flat_rd_row_c2 got %0d exp 1", r2); end
    if (x17 !== 6'd1) begin fails++; $display("FAIL flat_rd_x_c17 got %0d exp 1", x17); end
    if (min_sad !== 16'd0) begin fails++; $display("FAIL flat_min_sad got %0d exp 0", min_sad); end
    if (mv_x !== -7'sd16) begin fails++; $display("FAIL flat_mv_x got %0d exp -16", mv_x); end
    if (mv_y !== -7'sd16) begin fails++; $display("FAIL flat_mv_y got %0d exp -16", mv_y); end
    @(negedge clk);
    if (valid !== 1'b0) begin fails++; $display("FAIL flat_valid_one_cycle got %0d exp 0", valid); end
    if (busy !== 1'b0) begin fails++; $display("FAIL flat_busy_after got %0d exp 0", busy); end
  endtask

  task automatic load_shift;
    for (int r = 0; r < M; r++) for (int c = 0; c < M; c++) cur[r][c] = 8'($urandom_range(0, 255));
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) win[r][c] = 8'($urandom_range(0, 255));
    for (int r = 0; r < M; r++) for (int c = 0; c < M; c++) win[11 + r][19 + c] = cur[r][c];
  endtask

  task automatic test_shifted_match;
    int n;
    logic b1;
    logic [3:0] r2;
    logic [5:0] x17;
    load_shift();
    run_search(0, n, b1, r2, x17);
    checks += 4;
`ifdef ME_EARLY_TERM_EN
    if (!valid || n > K + 2) begin fails++; $display("FAIL shift_latency got %0d exp <=%0d", n, K + 2); end
`else
    if (!valid || n != K + 2) begin fails++; $display("FAIL shift_latency got %0d exp %0d", n, K + 2); end
`endif
    if (min_sad !== 16'd0) begin fails++; $display("FAIL shift_min_sad got %0d exp 0", min_sad); end
    if (mv_x !== 7'sd3) begin fails++; $display("FAIL shift_mv_x got %0d exp 3", mv_x); end
    if (mv_y !== -7'sd5) begin fails++; $display("FAIL shift_mv_y got %0d exp -5", mv_y); end
  endtask

  task automatic test_reset_mid_then_centre;
    int n;
    logic b1;
    logic [3:0] r2;
    logic [5:0] x17;
    load_shift();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4999) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks += 4;
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got %0d exp 0", busy); end
    if (rd_en !== 1'b0) begin fails++; $display("FAIL mid_reset_rd_en got %0d exp 0", rd_en); end
    if (valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid got %0d exp 0", valid); end
    if (min_sad !== 16'd0) begin fails++; $display("FAIL mid_reset_min_sad got %0d exp 0", min_sad); end
    for (int r = 0; r < M; r++) for (int c = 0; c < M; c++) cur[r][c] = 8'((r * 16 + c) % 250);
    for (int r = 0; r < S; r++) for (int c = 0; c < S; c++) win[r][c] = cur[r % M][c % M] + 8'd1;
    for (int r = 0; r < M; r++) for (int c = 0; c < M; c++) win[16 + r][16 + c] = cur[r][c];
    run_search(0, n, b1, r2, x17);
    checks += 4;
`ifdef ME_EARLY_TERM_EN
    if (!valid || n >= K + 2) begin fails++; $display("FAIL centre_latency got %0d exp <%0d", n, K + 2); end
`else
    if (!valid || n != K + 2) begin fails++; $display("FAIL centre_latency got %0d exp %0d", n, K + 2); end
`endif
    if (min_sad !== 16'd0) begin fails++; $display("FAIL centre_min_sad got %0d exp 0", min_sad); end
    if (mv_x !== 7'sd0) begin fails++; $display("FAIL centre_mv_x got %0d exp 0", mv_x); end
    if (mv_y !== 7'sd0) begin fails++; $display("FAIL centre_mv_y got %0d exp 0", mv_y); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pixel_cpr_in = '0;
    pixel_spr_in = '0;
    test_reset();
    test_flat_and_ignored_start();
    test_shifted_match();
    test_reset_mid_then_centre();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
